// File: rtl/wb_scoreboard.sv
// Register/CSR hazard scoreboard: per-register pending-write counters gate issue,
// writeback retires them, flush clears everything.
module wb_scoreboard (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rj,
   input  logic [4:0]  issue_rk,
   input  logic [4:0]  issue_rd,
   input  logic        use_rj,
   input  logic        use_rk,
   input  logic        use_rd,
   input  logic        issue_wr_rd,
   input  logic        issue_rd_csr,
   input  logic        issue_wr_csr,
   input  logic        wb_reg_we,
   input  logic [4:0]  wb_reg_idx,
   input  logic        wb_csr_we,
   input  logic        flush,
   output logic        issue_stall,
   output logic [31:0] busy_mask,
   output logic        sb_err
);

   logic [1:0] cnt_q [32];
   logic [1:0] cnt_d [32];
   logic [1:0] csr_cnt_q, csr_cnt_d;
   logic       sb_err_q, sb_err_d;
   logic       accept;
   logic       reg_inc, reg_dec, csr_inc;

   // Stall uses registered counts only; a same-cycle writeback is not forwarded.
   always_comb begin
      issue_stall = 1'b0;
      if (issue_valid) begin
         issue_stall = (use_rj && issue_rj != '0 && cnt_q[issue_rj] != '0)
                    || (use_rk && issue_rk != '0 && cnt_q[issue_rk] != '0)
                    || (use_rd && issue_rd != '0 && cnt_q[issue_rd] != '0)
                    || (issue_wr_rd && issue_rd != '0 && cnt_q[issue_rd] == '1)
                    || (issue_rd_csr && csr_cnt_q != '0)
                    || (issue_wr_csr && csr_cnt_q == '1);
      end
   end

   assign accept  = issue_valid & ~issue_stall & ~flush;
   assign reg_inc = accept & issue_wr_rd & (issue_rd != '0);
   assign reg_dec = wb_reg_we & (wb_reg_idx != '0);
   assign csr_inc = accept & issue_wr_csr;

   always_comb begin
      cnt_d     = cnt_q;
      csr_cnt_d = csr_cnt_q;
      sb_err_d  = sb_err_q;
      cnt_d[0]  = '0;
      if (flush) begin
         for (int unsigned i = 0; i < 32; i++) cnt_d[i] = '0;
         csr_cnt_d = '0;
      end else begin
         for (int unsigned i = 1; i < 32; i++) begin
            if (reg_inc && issue_rd == 5'(i) && !(reg_dec && wb_reg_idx == 5'(i))) begin
               if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (reg_dec && wb_reg_idx == 5'(i) && !(reg_inc && issue_rd == 5'(i))) begin
               if (cnt_q[i] == '0) sb_err_d = 1'b1;
               else                cnt_d[i] = cnt_q[i] - 2'd1;
            end
         end
         if (csr_inc && !wb_csr_we) begin
            if (csr_cnt_q != '1) csr_cnt_d = csr_cnt_q + 2'd1;
         end else if (wb_csr_we && !csr_inc) begin
            if (csr_cnt_q == '0) sb_err_d = 1'b1;
            else                 csr_cnt_d = csr_cnt_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= '0;
         csr_cnt_q <= '0;
         sb_err_q  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
         csr_cnt_q <= csr_cnt_d;
         sb_err_q  <= sb_err_d;
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int unsigned i = 1; i < 32; i++) busy_mask[i] = (cnt_q[i] != '0);
   end

   assign sb_err = sb_err_q;

endmodule
